// File: rtl/mem_access_ctrl.sv
// Memory access controller: JTAG command stream to dual-port RAM, plus an
// independent manual browse pointer whose data is refreshed in idle RAM cycles.
`timescale 1ns/1ps
module mem_access_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 2**ADDR_WIDTH,
  parameter int LEN_WIDTH  = 8,
  parameter int RD_LATENCY = 1,
  parameter bit AUTO_INC   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  rsp_valid,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] cur_addr,
  output logic                  busy,
  output logic                  addr_err,
  input  logic                  man_inc,
  input  logic                  man_dec,
  output logic [ADDR_WIDTH-1:0] man_addr,
  output logic [DATA_WIDTH-1:0] man_data,
  output logic                  man_valid,
  output logic [ADDR_WIDTH-1:0] ram_wraddress,
  output logic [ADDR_WIDTH-1:0] ram_rdaddress,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WRITE     = 3'd1;
  localparam logic [2:0] ST_FILL      = 3'd2;
  localparam logic [2:0] ST_READ_WAIT = 3'd3;
  localparam logic [2:0] ST_MAN_WAIT  = 3'd4;

  localparam logic [1:0] OP_SETADDR = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_READ    = 2'b10;
  localparam logic [1:0] OP_FILL    = 2'b11;

  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = LEN_WIDTH'(1);
  localparam logic [1:0]            LAT_LAST  = 2'(RD_LATENCY - 1);

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [LEN_WIDTH-1:0]  fill_cnt_q, fill_cnt_d;
  logic [1:0]            lat_cnt_q, lat_cnt_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
  logic [DATA_WIDTH-1:0] rsp_hold_q, rsp_hold_d;
  logic                  addr_err_q, addr_err_d;
  logic [ADDR_WIDTH-1:0] man_addr_q, man_addr_d;
  logic [DATA_WIDTH-1:0] man_data_q, man_data_d;
  logic                  man_valid_q, man_valid_d;
  logic                  pending_q, pending_d;
  logic [ADDR_WIDTH-1:0] launch_addr_q, launch_addr_d;
  logic                  man_cap_q, man_cap_d;

  logic cmd_accept;
  logic refresh_start;
  logic host_wr;
  logic inc_only;
  logic dec_only;
  logic man_move;

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    if (!AUTO_INC) return a;
    if (a == LAST_ADDR) return '0;
    return a + ADDR_ONE;
  endfunction

  assign cmd_accept    = cmd_valid && (state_q == ST_IDLE);
  assign refresh_start = !cmd_valid && pending_q && (state_q == ST_IDLE);
  assign host_wr       = (state_q == ST_WRITE) || (state_q == ST_FILL);
  assign inc_only      = man_inc && !man_dec;
  assign dec_only      = man_dec && !man_inc;
  assign man_move      = (inc_only && (man_addr_q != LAST_ADDR)) ||
                         (dec_only && (man_addr_q != '0));

  // Host command FSM; the read-response advance is applied first so a
  // SETADDR accepted in the response cycle overrides it.
  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    wr_data_d     = wr_data_q;
    fill_cnt_d    = fill_cnt_q;
    lat_cnt_d     = lat_cnt_q;
    rsp_valid_d   = 1'b0;
    rsp_addr_d    = rsp_addr_q;
    rsp_hold_d    = rsp_hold_q;
    addr_err_d    = addr_err_q;
    launch_addr_d = launch_addr_q;
    man_cap_d     = 1'b0;

    if (rsp_valid_q) begin
      cur_addr_d = next_addr(cur_addr_q);
      rsp_hold_d = ram_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_accept) begin
          case (cmd_op)
            OP_SETADDR: begin
              if ({1'b0, cmd_addr} < DEPTH_EXT) cur_addr_d = cmd_addr;
              else addr_err_d = 1'b1;
            end
            OP_WRITE: begin
              wr_data_d = cmd_data;
              state_d   = ST_WRITE;
            end
            OP_READ: begin
              lat_cnt_d = LAT_LAST;
              state_d   = ST_READ_WAIT;
            end
            default: begin
              wr_data_d  = cmd_data;
              fill_cnt_d = cmd_len;
              state_d    = ST_FILL;
            end
          endcase
        end else if (refresh_start) begin
          launch_addr_d = man_addr_q;
          lat_cnt_d     = LAT_LAST;
          state_d       = ST_MAN_WAIT;
        end
      end
      ST_WRITE: begin
        cur_addr_d = next_addr(cur_addr_q);
        state_d    = ST_IDLE;
      end
      ST_FILL: begin
        cur_addr_d = next_addr(cur_addr_q);
        if (fill_cnt_q == '0) state_d = ST_IDLE;
        else fill_cnt_d = fill_cnt_q - LEN_ONE;
      end
      ST_READ_WAIT: begin
        if (lat_cnt_q == 2'd0) begin
          rsp_valid_d = 1'b1;
          rsp_addr_d  = cur_addr_q;
          state_d     = ST_IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q - 2'd1;
        end
      end
      ST_MAN_WAIT: begin
        if (lat_cnt_q == 2'd0) begin
          man_cap_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q - 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Browse pointer; invalidation is evaluated last so it beats a capture in
  // the same cycle and forces another refresh.
  always_comb begin
    man_addr_d  = man_addr_q;
    man_data_d  = man_data_q;
    man_valid_d = man_valid_q;
    pending_d   = pending_q;

    if (refresh_start) pending_d = 1'b0;

    if (man_cap_q && !pending_q && (man_addr_q == launch_addr_q)) begin
      man_data_d  = ram_q;
      man_valid_d = 1'b1;
    end

    if (man_move) begin
      man_addr_d  = inc_only ? (man_addr_q + ADDR_ONE) : (man_addr_q - ADDR_ONE);
      pending_d   = 1'b1;
      man_valid_d = 1'b0;
    end

    if (host_wr) begin
      pending_d   = 1'b1;
      man_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cur_addr_q    <= '0;
      wr_data_q     <= '0;
      fill_cnt_q    <= '0;
      lat_cnt_q     <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_addr_q    <= '0;
      rsp_hold_q    <= '0;
      addr_err_q    <= 1'b0;
      man_addr_q    <= '0;
      man_data_q    <= '0;
      man_valid_q   <= 1'b0;
      pending_q     <= 1'b1;
      launch_addr_q <= '0;
      man_cap_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      wr_data_q     <= wr_data_d;
      fill_cnt_q    <= fill_cnt_d;
      lat_cnt_q     <= lat_cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_addr_q    <= rsp_addr_d;
      rsp_hold_q    <= rsp_hold_d;
      addr_err_q    <= addr_err_d;
      man_addr_q    <= man_addr_d;
      man_data_q    <= man_data_d;
      man_valid_q   <= man_valid_d;
      pending_q     <= pending_d;
      launch_addr_q <= launch_addr_d;
      man_cap_q     <= man_cap_d;
    end
  end

  // The RAM's registered read word is on ram_q during the response cycle
  // itself, so it is forwarded then and held afterwards.
  assign rsp_data      = rsp_valid_q ? ram_q : rsp_hold_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_addr      = rsp_addr_q;
  assign cmd_ready     = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign cur_addr      = cur_addr_q;
  assign addr_err      = addr_err_q;
  assign man_addr      = man_addr_q;
  assign man_data      = man_data_q;
  assign man_valid     = man_valid_q;
  assign ram_wraddress = cur_addr_q;
  assign ram_data      = wr_data_q;
  assign ram_wren      = host_wr;
  assign ram_rdaddress = (state_q == ST_READ_WAIT) ? cur_addr_q : man_addr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with DEPTH=100 and a two-cycle RAM model;
// RAM preloaded with addr ^ 0x5A.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 16;
  localparam int DEPTH = 100;
  localparam int LW    = 8;
  localparam int RDL   = 2;

  localparam logic [1:0] OP_SETADDR = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_READ    = 2'b10;
  localparam logic [1:0] OP_FILL    = 2'b11;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic [LW-1:0] cmd_len;
  logic          rsp_valid;
  logic [AW-1:0] rsp_addr;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] cur_addr;
  logic          busy;
  logic          addr_err;
  logic          man_inc;
  logic          man_dec;
  logic [AW-1:0] man_addr;
  logic [DW-1:0] man_data;
  logic          man_valid;
  logic [AW-1:0] ram_wraddress;
  logic [AW-1:0] ram_rdaddress;
  logic [DW-1:0] ram_data;
  logic          ram_wren;
  logic [DW-1:0] ram_q;

  int numCompared   = 0;
  int numMismatched = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
    .LEN_WIDTH(LW), .RD_LATENCY(RDL), .AUTO_INC(1'b1)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_len(cmd_len),
    .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .cur_addr(cur_addr), .busy(busy), .addr_err(addr_err),
    .man_inc(man_inc), .man_dec(man_dec), .man_addr(man_addr),
    .man_data(man_data), .man_valid(man_valid),
    .ram_wraddress(ram_wraddress), .ram_rdaddress(ram_rdaddress),
    .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  // Dual-port RAM with a two-stage registered read path
  logic [DW-1:0] mem [0:DEPTH-1];
  logic [DW-1:0] rdStage;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i) ^ 8'h5A;
  end

  always @(posedge clk) begin
    if (ram_wren && (ram_wraddress < 16'(DEPTH))) mem[ram_wraddress[6:0]] <= ram_data;
    rdStage <= (ram_rdaddress < 16'(DEPTH)) ? mem[ram_rdaddress[6:0]] : '0;
    ram_q   <= rdStage;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present one command, wait (bounded) for acceptance, return in the cycle after the accept edge
  task automatic applyStimulus(input logic [1:0] op, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data, input logic [LW-1:0] len);
    int waitCycles;
    waitCycles = 0;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    cmd_len   = len;
    cmd_valid = 1'b1;
    while (!cmd_ready && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("accept_wait", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic stepMan(input logic inc, input logic dec);
    man_inc = inc;
    man_dec = dec;
    @(negedge clk);
    man_inc = 1'b0;
    man_dec = 1'b0;
  endtask

  task automatic waitRsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int rspSeen;
    logic [AW-1:0] fillAddr [4];
    fillAddr = '{16'd98, 16'd99, 16'd0, 16'd1};

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0;
    cmd_data = '0; cmd_len = '0; man_inc = 1'b0; man_dec = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_cur_addr", 32'(cur_addr), 32'd0);
    checkOutput("rst_addr_err", 32'(addr_err), 32'd0);
    checkOutput("rst_man_valid", 32'(man_valid), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_ram_wren", 32'(ram_wren), 32'd0);

    // Power-on refresh of address 0
    reset = 1'b0;
    @(negedge clk);
    checkOutput("boot_refresh_busy", 32'(busy), 32'd1);
    checkOutput("boot_refresh_stall", 32'(cmd_ready), 32'd0);
    repeat (4) @(negedge clk);
    checkOutput("boot_man_valid", 32'(man_valid), 32'd1);
    checkOutput("boot_man_addr", 32'(man_addr), 32'd0);
    checkOutput("boot_man_data", 32'(man_data), 32'h5A);
    checkOutput("boot_addr_err", 32'(addr_err), 32'd0);

    // Write then read back
    applyStimulus(OP_SETADDR, 16'h0010, 8'h00, 8'd0);
    applyStimulus(OP_WRITE, 16'h0000, 8'hA5, 8'd0);
    checkOutput("wr_wren", 32'(ram_wren), 32'd1);
    checkOutput("wr_addr", 32'(ram_wraddress), 32'h10);
    checkOutput("wr_data", 32'(ram_data), 32'hA5);
    @(negedge clk);
    checkOutput("wr_one_cycle", 32'(ram_wren), 32'd0);
    checkOutput("wr_ready_again", 32'(cmd_ready), 32'd1);
    checkOutput("wr_advance", 32'(cur_addr), 32'h11);
    applyStimulus(OP_SETADDR, 16'h0010, 8'h00, 8'd0);
    applyStimulus(OP_READ, 16'h0000, 8'h00, 8'd0);
    checkOutput("rd_not_early", 32'(rsp_valid), 32'd0);
    waitRsp(lat);
    checkOutput("rd_latency", 32'(lat), 32'd2);
    checkOutput("rd_rsp_addr", 32'(rsp_addr), 32'h10);
    checkOutput("rd_rsp_data", 32'(rsp_data), 32'hA5);
    checkOutput("rd_ready_in_rsp", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    checkOutput("rd_pulse_one", 32'(rsp_valid), 32'd0);
    checkOutput("rd_advance", 32'(cur_addr), 32'h11);

    // FILL across the DEPTH wrap
    applyStimulus(OP_SETADDR, 16'd98, 8'h00, 8'd0);
    applyStimulus(OP_FILL, 16'h0000, 8'h3C, 8'd3);
    for (int k = 0; k < 4; k++) begin
      checkOutput("fill_wren", 32'(ram_wren), 32'd1);
      checkOutput("fill_addr", 32'(ram_wraddress), 32'(fillAddr[k]));
      checkOutput("fill_data", 32'(ram_data), 32'h3C);
      @(negedge clk);
    end
    checkOutput("fill_done_wren", 32'(ram_wren), 32'd0);
    checkOutput("fill_done_ready", 32'(cmd_ready), 32'd1);
    checkOutput("fill_cur_addr", 32'(cur_addr), 32'd2);

    // SETADDR range boundary
    applyStimulus(OP_SETADDR, 16'd99, 8'h00, 8'd0);
    checkOutput("set99_addr", 32'(cur_addr), 32'd99);
    checkOutput("set99_err", 32'(addr_err), 32'd0);
    applyStimulus(OP_SETADDR, 16'd100, 8'h00, 8'd0);
    checkOutput("set100_addr", 32'(cur_addr), 32'd99);
    checkOutput("set100_err", 32'(addr_err), 32'd1);
    applyStimulus(OP_SETADDR, 16'd150, 8'h00, 8'd0);
    checkOutput("set150_addr", 32'(cur_addr), 32'd99);
    checkOutput("set150_err", 32'(addr_err), 32'd1);

    // Read at the last address wraps the pointer
    applyStimulus(OP_READ, 16'h0000, 8'h00, 8'd0);
    waitRsp(lat);
    checkOutput("rd99_latency", 32'(lat), 32'd2);
    checkOutput("rd99_rsp_addr", 32'(rsp_addr), 32'd99);
    checkOutput("rd99_rsp_data", 32'(rsp_data), 32'h3C);
    @(negedge clk);
    checkOutput("rd99_wrap", 32'(cur_addr), 32'd0);

    // Manual pointer stepping and refresh
    repeat (10) @(negedge clk);
    checkOutput("man0_valid", 32'(man_valid), 32'd1);
    checkOutput("man0_data_after_fill", 32'(man_data), 32'h3C);
    checkOutput("err_sticky", 32'(addr_err), 32'd1);
    stepMan(1'b0, 1'b1);
    checkOutput("man_dec_sat", 32'(man_addr), 32'd0);
    checkOutput("man_dec_sat_valid", 32'(man_valid), 32'd1);
    repeat (5) stepMan(1'b1, 1'b0);
    checkOutput("man_inc5", 32'(man_addr), 32'd5);
    checkOutput("man_inc_invalid", 32'(man_valid), 32'd0);
    stepMan(1'b1, 1'b1);
    checkOutput("man_both", 32'(man_addr), 32'd5);
    repeat (10) @(negedge clk);
    checkOutput("man5_valid", 32'(man_valid), 32'd1);
    checkOutput("man5_data", 32'(man_data), 32'h5F);

    applyStimulus(OP_SETADDR, 16'd5, 8'h00, 8'd0);
    applyStimulus(OP_WRITE, 16'h0000, 8'h77, 8'd0);
    @(negedge clk);
    checkOutput("man_wr_invalid", 32'(man_valid), 32'd0);
    repeat (10) @(negedge clk);
    checkOutput("man_wr_valid", 32'(man_valid), 32'd1);
    checkOutput("man_wr_data", 32'(man_data), 32'h77);

    repeat (94) stepMan(1'b1, 1'b0);
    checkOutput("man_inc_to_top", 32'(man_addr), 32'd99);
    stepMan(1'b1, 1'b0);
    checkOutput("man_inc_sat", 32'(man_addr), 32'd99);
    repeat (10) @(negedge clk);
    checkOutput("man99_data", 32'(man_data), 32'h3C);

    // Host READ beats a pending refresh; the refresh follows the response
    stepMan(1'b0, 1'b1);
    applyStimulus(OP_READ, 16'h0000, 8'h00, 8'd0);
    checkOutput("prio_rdaddress", 32'(ram_rdaddress), 32'd6);
    waitRsp(lat);
    checkOutput("prio_latency", 32'(lat), 32'd2);
    checkOutput("prio_rsp_addr", 32'(rsp_addr), 32'd6);
    checkOutput("prio_rsp_data", 32'(rsp_data), 32'h5C);
    checkOutput("prio_man_invalid", 32'(man_valid), 32'd0);
    @(negedge clk);
    checkOutput("prio_refresh_busy", 32'(busy), 32'd1);
    checkOutput("prio_refresh_stall", 32'(cmd_ready), 32'd0);
    repeat (6) @(negedge clk);
    checkOutput("prio_man_valid", 32'(man_valid), 32'd1);
    checkOutput("prio_man_data", 32'(man_data), 32'h3C);
    checkOutput("prio_cur_addr", 32'(cur_addr), 32'd7);

    // Reset during FILL
    applyStimulus(OP_SETADDR, 16'd10, 8'h00, 8'd0);
    applyStimulus(OP_FILL, 16'h0000, 8'hEE, 8'd7);
    checkOutput("rstfill_wren_before", 32'(ram_wren), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rstfill_wren", 32'(ram_wren), 32'd0);
    checkOutput("rstfill_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rstfill_cur_addr", 32'(cur_addr), 32'd0);
    checkOutput("rstfill_addr_err", 32'(addr_err), 32'd0);
    checkOutput("rstfill_man_addr", 32'(man_addr), 32'd0);
    checkOutput("rstfill_man_valid", 32'(man_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("rstfill_refresh_valid", 32'(man_valid), 32'd1);
    checkOutput("rstfill_refresh_data", 32'(man_data), 32'h3C);

    // Reset during READ_WAIT suppresses the response
    applyStimulus(OP_READ, 16'h0000, 8'h00, 8'd0);
    reset = 1'b1;
    rspSeen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 2) reset = 1'b0;
      if (rsp_valid) rspSeen++;
    end
    checkOutput("rstread_no_rsp", 32'(rspSeen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
